rng_fill_ctrl: RTL and testbench

RNG_FILL_CTRL -- requirements
Module: rng_fill_ctrl

---
 rtl/rng_fill_ctrl.sv | 113 +++++++++++
 tb/tb_rng_fill_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_fill_ctrl.sv
// Packs serial LFSR bits into FIFO words and keeps the FIFO topped up above a
// low-water mark, tracking occupancy from observed pushes and accepted pops.
module rng_fill_ctrl #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          lfsr_out,
  input  logic                          lfsr_valid,
  output logic                          lfsr_enable,
  output logic                          fifo_push,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_pop,
  input  logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic [7:0]                    drop_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(FIFO_WIDTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LOW_L   = LW'(LOW_WATER);
  localparam logic [CW-1:0] LAST_L  = CW'(FIFO_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, PUSH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FIFO_WIDTH-1:0] shreg_q, shreg_d;
  logic [FIFO_WIDTH-1:0] word_q, word_d;
  logic [LW-1:0]         level_q, level_d;
  logic [7:0]            drop_q, drop_d;
  logic                  push_acc;
  logic                  pop_acc;

  assign push_acc = (state_q == PUSH) && !fifo_full;
  assign pop_acc  = fifo_pop && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    level_d   = level_q;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (enable && (level_q <= LOW_L)) state_d = FILL;
      end
      FILL: begin
        // enable is deliberately ignored here so a started word always completes
        if (lfsr_valid) begin
          shreg_d = {shreg_q[FIFO_WIDTH-2:0], lfsr_out};
          if (bit_cnt_q == LAST_L) begin
            word_d    = shreg_d;
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PUSH: begin
        if (push_acc) begin
          if (!enable || (level_q + 1'b1 == DEPTH_L)) state_d = IDLE;
          else                                         state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lfsr_valid && (state_q != FILL) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    if (push_acc && !pop_acc && (level_q != DEPTH_L))
      level_d = level_q + 1'b1;
    else if (pop_acc && !push_acc && (level_q != '0))
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      level_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
    end
  end

  // Status outputs decode straight from registers; only fifo_push sees an input
  assign lfsr_enable  = (state_q == FILL);
  assign busy         = (state_q != IDLE);
  assign fifo_push    = push_acc;
  assign fifo_data_in = word_q;
  assign level        = level_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_rng_fill_ctrl.sv
// Scoreboard bench: stimulus queues serial bits and the words they should form;
// a monitor pops expected words whenever the controller pushes into the FIFO.
module tb_rng_fill_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       lfsr_out = 1'b0;
  logic       lfsr_valid = 1'b0;
  logic       lfsr_enable;
  logic       fifo_push;
  logic [7:0] fifo_data_in;
  logic       fifo_full;
  logic       fifo_pop = 1'b0;
  logic       fifo_empty;
  logic [3:0] level;
  logic       busy;
  logic [7:0] drop_count;

  logic       force_full = 1'b0;
  bit         raw_mode = 1'b0;
  int         tb_cnt;
  logic [7:0] exp_q[$];
  bit         bitq[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  rng_fill_ctrl #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .LOW_WATER(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lfsr_out(lfsr_out),
    .lfsr_valid(lfsr_valid), .lfsr_enable(lfsr_enable), .fifo_push(fifo_push),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_pop(fifo_pop),
    .fifo_empty(fifo_empty), .level(level), .busy(busy), .drop_count(drop_count)
  );

  // Environment FIFO occupancy, so full/empty flags behave like a real FIFO
  assign fifo_full  = force_full || (tb_cnt == 8);
  assign fifo_empty = (tb_cnt == 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else if (fifo_push && !(fifo_pop && !fifo_empty)) tb_cnt <= tb_cnt + 1;
    else if (!fifo_push && fifo_pop && !fifo_empty)   tb_cnt <= tb_cnt - 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Bit source: serves queued bits whenever the controller asks for them
  always @(negedge clk) begin
    if (raw_mode) begin
      lfsr_valid = 1'b1;
      lfsr_out   = 1'b0;
    end else if (lfsr_enable && bitq.size() > 0) begin
      lfsr_valid = 1'b1;
      lfsr_out   = bitq.pop_front();
    end else begin
      lfsr_valid = 1'b0;
    end
  end

  // Monitor: compare every FIFO push against the scoreboard
  always begin
    @(negedge clk);
    #1;
    if (fifo_push) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_push: got %0h required none at %0t", fifo_data_in, $time);
      end else begin
        chk("push_data", fifo_data_in, exp_q.pop_front());
      end
    end
  end

  task automatic queue_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) bitq.push_back(w[i]);
  endtask

  task automatic queue_word(input logic [7:0] w);
    exp_q.push_back(w);
    queue_bits(w, 7, 0);
  endtask

  task automatic wait_exp(input int limit, input string nm);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) timeout_fail(nm);
  endtask

  task automatic wait_bits(input int limit, input string nm);
    for (int i = 0; i < limit && bitq.size() != 0; i++) @(negedge clk);
    if (bitq.size() != 0) timeout_fail(nm);
  endtask

  task automatic wait_push_state(input int limit, input string nm);
    for (int i = 0; i < limit && !(busy && !lfsr_enable); i++) @(negedge clk);
    if (!(busy && !lfsr_enable)) timeout_fail(nm);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_drop"}, drop_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lfsr_en"}, lfsr_enable, 0);
    chk({tag, "_push"}, fifo_push, 0);
    chk({tag, "_data"}, fifo_data_in, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    enable  = 1'b1;
    reset_n = 1'b1;

    // Single word 1,0,1,1,0,0,1,0 -> B2, then filling resumes
    queue_word(8'hB2);
    wait_exp(60, "wait_b2");
    chk("b2_level", level, 1);
    chk("b2_refill", lfsr_enable, 1);

    // Fill to the top with no consumer
    for (int k = 1; k <= 7; k++) queue_word(8'(k * 8'h11));
    wait_exp(300, "wait_fill");
    chk("full_level", level, 8);
    chk("full_busy", busy, 0);
    chk("full_lfsr_en", lfsr_enable, 0);
    chk("full_drop", drop_count, 0);

    // Drain 6 words; refill starts the cycle after level reaches 2
    @(negedge clk);
    fifo_pop = 1'b1;
    repeat (6) @(negedge clk);
    fifo_pop = 1'b0;
    chk("drain_level", level, 2);
    chk("drain_idle", busy, 0);
    @(negedge clk);
    chk("lowwater_fill", lfsr_enable, 1);

    // FIFO full while a word is pending: hold word, no push
    force_full = 1'b1;
    queue_word(8'h5A);
    wait_push_state(60, "wait_push_5a");
    for (int k = 0; k < 5; k++) begin
      chk("hold_push", fifo_push, 0);
      chk("hold_data", fifo_data_in, 8'h5A);
      @(negedge clk);
    end
    force_full = 1'b0;
    wait_exp(10, "wait_5a");
    chk("5a_level", level, 3);

    // Push and accepted pop in the same cycle at level 3
    force_full = 1'b1;
    queue_word(8'hC3);
    wait_push_state(60, "wait_push_c3");
    force_full = 1'b0;
    fifo_pop   = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    chk("pushpop_level", level, 3);
    wait_exp(10, "wait_c3");

    // Enable dropped after 3 bits: the word still completes, then IDLE
    exp_q.push_back(8'hE7);
    queue_bits(8'hE7, 7, 5);
    wait_bits(60, "wait_3bits");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    queue_bits(8'hE7, 4, 0);
    wait_exp(60, "wait_e7");
    chk("e7_busy", busy, 0);
    chk("e7_level", level, 4);
    chk("e7_lfsr_en", lfsr_enable, 0);

    // Drain to empty, then pops on an empty FIFO must not underflow
    fifo_pop = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain0_level", level, 0);
    repeat (2) @(negedge clk);
    fifo_pop = 1'b0;
    chk("empty_pop_level", level, 0);

    // Valid bits while IDLE are dropped and counted with saturation
    chk("pre_drop", drop_count, 0);
    raw_mode = 1'b1;
    repeat (300) @(negedge clk);
    raw_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_sat", drop_count, 255);
    chk("drop_idle", busy, 0);

    // Reset in the middle of a word, then a fresh word
    enable = 1'b1;
    queue_bits(8'hFF, 7, 3);
    wait_bits(60, "wait_5bits");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    queue_word(8'h96);
    wait_exp(60, "wait_96");
    chk("fresh_level", level, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
